alu_step_seq: RTL
=================

ALU_STEP_SEQ -- requirements
Module: alu_step_seq

Interface
REQ-001 clk  in  1  single system clock; all state updates on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start  in  1  request; sampled only in IDLE.
REQ-004 op  in  3  operation code q2 q1 q0.
REQ-005 a_in  in  16  operand A.
REQ-006 b_in  in  16  operand B.
REQ-007 step_en  in  1  1 = single-step mode.
REQ-008 step  in  1  step request; rising edge is detected internally.
REQ-009 x, y, z, u, v  out  1 each  ALU control signals.
REQ-010 als_h4  out  1  enables the ALU result onto the S-bus.
REQ-011 a_bus, b_bus  out  16 each  ALU operand buses.
REQ-012 s_bus  in  16  ALU gated result.
REQ-013 carry, overflow  in  1 each  ALU flags.
REQ-014 result  out  16  registered result.
REQ-015 c_flag, v_flag, z_flag  out  1 each  registered flags.
REQ-016 busy  out  1  high in LOAD, EXEC and WRITE.
REQ-017 done  out  1  one-cycle pulse in DONE.
REQ-018 state  out  3  encoding: IDLE=0, LOAD=1, EXEC=2, WRITE=3, DONE=4.

Function
REQ-019 In IDLE, start=1 SHALL latch op, a_in and b_in into internal registers and move to LOAD.
REQ-020 Transitions SHALL be LOAD->EXEC->WRITE->DONE->IDLE.
REQ-021 With step_en=0, each transition SHALL take one cycle, so done asserts exactly 4 cycles after the cycle in which start was sampled.
REQ-022 With step_en=1, LOAD->EXEC, EXEC->WRITE and WRITE->DONE SHALL occur only on a cycle in which a step rising edge is detected; DONE->IDLE and IDLE->LOAD SHALL not require a step edge.
REQ-023 A change of step_en SHALL take effect on the next transition decision.
REQ-024 start while busy or in DONE SHALL be ignored and SHALL not be queued.
REQ-025 From LOAD through WRITE, x y z u v SHALL be decoded from the latched op:
- 000 -> 01001 (ADD)
- 001 -> 01011 (INC)
- 010 -> 11011 (SUB)
- 011 -> 11001 (DEC)
- 100 -> 00000 (AND)
- 101 -> 00100 (OR)
- 110 -> 00001 (XOR)
- 111 -> 10001 (NOT)
REQ-026 In IDLE and DONE, x y z u v and als_h4 SHALL be 0, and a_bus and b_bus SHALL be 0.
REQ-027 From LOAD through WRITE, a_bus SHALL equal the latched A (forced to 0 when op=111), and b_bus SHALL equal the latched B.
REQ-028 als_h4 SHALL be 0 in LOAD and 1 in EXEC and WRITE.
REQ-029 On the cycle leaving WRITE, result SHALL be loaded from s_bus and z_flag SHALL be set to (s_bus==0).
REQ-030 On the same cycle, c_flag and v_flag SHALL be loaded from carry and overflow when op[2]=0, and cleared to 0 when op[2]=1.
REQ-031 result and all flags SHALL hold their values until the next WRITE exit or reset.
REQ-032 All arithmetic SHALL be 16-bit; the sequencer SHALL perform no arithmetic itself and SHALL not extend width.

Reset
REQ-033 rst=1 SHALL, on the next clock edge, force IDLE from any state, including mid-operation.
REQ-034 rst=1 SHALL clear result, all flags, the latched op/A/B, and the step edge-detector history to 0.
REQ-035 After reset, all outputs SHALL be 0.
REQ-036 rst SHALL have priority over start and over step.

Structure
REQ-037 A shared package SHALL hold the state encoding constants, the op codes, and the ALU control-vector constants.
REQ-038 The op-to-control decoder SHALL be one sub-module, alu_ctrl_dec: combinational, 3-bit in, 5-bit out, reusable by board-level wrappers.
REQ-039 Verification SHALL instantiate alu_step_seq with the existing H4 ALU block closing the a_bus/b_bus/control -> s_bus/carry/overflow loop.

Verification
REQ-040 ADD: op=000, A=0x00FF, B=0x0001, step_en=0 -> done exactly 4 cycles after start; result=0x0100, c=0, v=0, z=0.
REQ-041 SUB: op=010, A=0x0005, B=0x0007 -> result=0xFFFE, c=0, z=0; x y z u v = 11011 only during LOAD through WRITE.
REQ-042 NOT and XOR:
- op=111, A=0x1234, B=0x00F0 -> a_bus=0 during busy; result=0xFF0F, c=0, v=0.
- op=110, A=B=0xAAAA -> result=0x0000, z=1.
REQ-043 Overflow and ignored start: op=000, A=0x7FFF, B=0x0001 -> result=0x8000, v=1; a second start pulse during EXEC produces no second done.
REQ-044 Step mode: step_en=1, start, no step for 10 cycles -> state stays LOAD with busy=1; after three step rising edges -> done pulses once.
REQ-045 Reset mid-operation: rst asserted in EXEC -> next cycle state=IDLE, all outputs 0, prior result cleared.

Source files
------------

// File: rtl/alu_step_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_step_seq_pkg
// Shared definitions for the ALU step sequencer: datapath widths, the
// sequencer state encoding, the operation codes and the 5-bit ALU control
// vectors {x, y, z, u, v} that each operation drives onto the H4 ALU.
// -----------------------------------------------------------------------------
package alu_step_seq_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 3;
    localparam int CTRL_W = 5;

    // Encoding is visible on the state output, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_INC = 3'b001,
        OP_SUB = 3'b010,
        OP_DEC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } op_t;

    // ALU control vectors, bit order {x, y, z, u, v}.
    localparam logic [CTRL_W-1:0] CTRL_ADD  = 5'b01001;
    localparam logic [CTRL_W-1:0] CTRL_INC  = 5'b01011;
    localparam logic [CTRL_W-1:0] CTRL_SUB  = 5'b11011;
    localparam logic [CTRL_W-1:0] CTRL_DEC  = 5'b11001;
    localparam logic [CTRL_W-1:0] CTRL_AND  = 5'b00000;
    localparam logic [CTRL_W-1:0] CTRL_OR   = 5'b00100;
    localparam logic [CTRL_W-1:0] CTRL_XOR  = 5'b00001;
    localparam logic [CTRL_W-1:0] CTRL_NOT  = 5'b10001;
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 5'b00000;

    // States in which the sequencer owns the ALU and reports busy.
    function automatic logic is_active(input state_t s);
        return (s == ST_LOAD) || (s == ST_EXEC) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/alu_step_seq_if.sv
// -----------------------------------------------------------------------------
// alu_step_seq_if
// Bundles the sequencer's request, operand, ALU-loop and status signals.
//   master : requester + ALU side (drives start/op/operands/step and the ALU
//            response s_bus/carry/overflow; observes controls and status)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface alu_step_seq_if;
    import alu_step_seq_pkg::*;

    // request side
    logic              start;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              step_en;
    logic              step;
    // ALU controls and operand buses
    logic              x, y, z, u, v;
    logic              als_h4;
    logic [DATA_W-1:0] a_bus;
    logic [DATA_W-1:0] b_bus;
    // ALU response
    logic [DATA_W-1:0] s_bus;
    logic              carry;
    logic              overflow;
    // registered results and status
    logic [DATA_W-1:0] result;
    logic              c_flag, v_flag, z_flag;
    logic              busy;
    logic              done;
    logic [2:0]        state;

    modport master (
        output start, op, a_in, b_in, step_en, step, s_bus, carry, overflow,
        input  x, y, z, u, v, als_h4, a_bus, b_bus,
        input  result, c_flag, v_flag, z_flag, busy, done, state
    );

    modport slave (
        input  start, op, a_in, b_in, step_en, step, s_bus, carry, overflow,
        output x, y, z, u, v, als_h4, a_bus, b_bus,
        output result, c_flag, v_flag, z_flag, busy, done, state
    );

endinterface

// File: rtl/alu_step_seq_ctrl_dec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dec
// Combinational op-code to H4 ALU control decoder, kept standalone so board
// wrappers can drive the ALU directly without the sequencer.
//   op   in  3  operation code
//   ctrl out 5  {x, y, z, u, v}
// -----------------------------------------------------------------------------
module alu_ctrl_dec
    import alu_step_seq_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    output logic [CTRL_W-1:0] ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (op)
            OP_ADD:  ctrl = CTRL_ADD;
            OP_INC:  ctrl = CTRL_INC;
            OP_SUB:  ctrl = CTRL_SUB;
            OP_DEC:  ctrl = CTRL_DEC;
            OP_AND:  ctrl = CTRL_AND;
            OP_OR:   ctrl = CTRL_OR;
            OP_XOR:  ctrl = CTRL_XOR;
            OP_NOT:  ctrl = CTRL_NOT;
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/alu_step_seq.sv
// -----------------------------------------------------------------------------
// alu_step_seq
// Five-state sequencer (IDLE, LOAD, EXEC, WRITE, DONE) that drives an external
// H4 ALU through one operation and captures its result and flags. In
// single-step mode the three working transitions wait for a rising edge on
// step. The sequencer does no arithmetic of its own.
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of alu_step_seq_if (request, ALU loop, status)
// All outputs are registered.
// -----------------------------------------------------------------------------
module alu_step_seq
    import alu_step_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_step_seq_if.slave bus
);

    state_t              state_q;
    state_t              state_nxt;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [OP_W-1:0]     op_nxt;
    logic [DATA_W-1:0]   a_nxt;
    logic [DATA_W-1:0]   b_nxt;
    logic                capture;
    logic                step_q;
    logic                step_rise;
    logic                advance;
    logic [CTRL_W-1:0]   ctrl_nxt;
    logic [CTRL_W-1:0]   ctrl_q;
    logic                als_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   a_bus_q;
    logic [DATA_W-1:0]   b_bus_q;
    logic [DATA_W-1:0]   result_q;
    logic                c_q;
    logic                v_q;
    logic                z_q;

    assign step_rise = bus.step & ~step_q;
    // step_en is used live so a mode change applies to the very next decision.
    assign advance   = ~bus.step_en | step_rise;
    assign capture   = (state_q == ST_IDLE) && bus.start;

    // Outputs are registered from the next state, so the decoder and operand
    // buses must see the operands being latched on the IDLE->LOAD edge.
    assign op_nxt = capture ? bus.op   : op_q;
    assign a_nxt  = capture ? bus.a_in : a_q;
    assign b_nxt  = capture ? bus.b_in : b_q;

    alu_ctrl_dec u_ctrl_dec (
        .op   (op_nxt),
        .ctrl (ctrl_nxt)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_nxt = ST_LOAD;
            ST_LOAD:  if (advance)   state_nxt = ST_EXEC;
            ST_EXEC:  if (advance)   state_nxt = ST_WRITE;
            ST_WRITE: if (advance)   state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= CTRL_IDLE;
            als_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_bus_q  <= '0;
            b_bus_q  <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q <= state_nxt;
            step_q  <= bus.step;

            if (capture) begin
                op_q <= bus.op;
                a_q  <= bus.a_in;
                b_q  <= bus.b_in;
            end

            if (is_active(state_nxt)) begin
                ctrl_q  <= ctrl_nxt;
                // NOT is computed by the ALU as 0 combined with inverted B.
                a_bus_q <= (op_nxt == OP_NOT) ? '0 : a_nxt;
                b_bus_q <= b_nxt;
            end else begin
                ctrl_q  <= CTRL_IDLE;
                a_bus_q <= '0;
                b_bus_q <= '0;
            end

            als_q  <= (state_nxt == ST_EXEC) || (state_nxt == ST_WRITE);
            busy_q <= is_active(state_nxt);
            done_q <= (state_nxt == ST_DONE);

            // Capture on the edge that leaves WRITE; the ALU output is gated
            // onto s_bus throughout WRITE.
            if ((state_q == ST_WRITE) && advance) begin
                result_q <= bus.s_bus;
                z_q      <= (bus.s_bus == '0);
                // Logic ops leave the ALU carry/overflow meaningless.
                c_q      <= op_q[2] ? 1'b0 : bus.carry;
                v_q      <= op_q[2] ? 1'b0 : bus.overflow;
            end
        end
    end

    assign bus.x      = ctrl_q[4];
    assign bus.y      = ctrl_q[3];
    assign bus.z      = ctrl_q[2];
    assign bus.u      = ctrl_q[1];
    assign bus.v      = ctrl_q[0];
    assign bus.als_h4 = als_q;
    assign bus.a_bus  = a_bus_q;
    assign bus.b_bus  = b_bus_q;
    assign bus.result = result_q;
    assign bus.c_flag = c_q;
    assign bus.v_flag = v_q;
    assign bus.z_flag = z_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.state  = state_q;

endmodule
